// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 Set-2 receiver to ASCII; in clock/reset/ps2_clk/ps2_data, out key_reg[7:0], sample (toggle per key), frame_error (pulse)
module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_reg,
  output logic       sample,
  output logic       frame_error
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bits_q, bits_d;
  logic [7:0]    shreg_q, shreg_d, key_q, key_d, asc;
  logic          par_q, par_d, err_q, err_d, brk_q, brk_d, ext_q, ext_d;
  logic          shift_q, shift_d, sample_q, sample_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fe, din, tmo, good;
  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic sh);
    logic [7:0] a;
    case (c)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    return (sh && a >= 8'h61 && a <= 8'h7A) ? a - 8'h20 : a;
  endfunction
  assign fe  = clk_sync_q[2] & ~clk_sync_q[1];
  assign din = data_sync_q[1];
  assign tmo = cnt_q == CW'(TIMEOUT_CYCLES);
  assign asc = to_ascii(shreg_q, shift_q);
  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    state_d     = state_q;
    bits_d      = bits_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    cnt_d       = fe ? '0 : tmo ? cnt_q : cnt_q + CW'(1);
    err_d       = 1'b0;
    good        = 1'b0;
    brk_d       = brk_q;
    ext_d       = ext_q;
    shift_d     = shift_q;
    key_d       = key_q;
    sample_d    = sample_q;
    if (fe) begin
      case (state_q)
        IDLE: if (!din) begin
          state_d = DATA;
          bits_d  = 3'd0;
        end
        DATA: begin
          shreg_d = {din, shreg_q[7:1]};
          bits_d  = bits_q + 3'd1;
          state_d = bits_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          good    = din & (^shreg_q ^ par_q);
          err_d   = ~good;
        end
      endcase
    end else if (state_q != IDLE && tmo) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
    if (good) begin
      if (shreg_q == 8'hF0) brk_d = 1'b1;
      else if (shreg_q == 8'hE0) ext_d = 1'b1;
      else begin
        if (shreg_q == 8'h12 || shreg_q == 8'h59) shift_d = ~brk_q;
        else if (!brk_q && !ext_q && asc != 8'h00) begin
          key_d    = asc;
          sample_d = ~sample_q;
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
      state_q     <= IDLE;
      bits_q      <= 3'd0;
      shreg_q     <= 8'h00;
      par_q       <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      shift_q     <= 1'b0;
      key_q       <= 8'h00;
      sample_q    <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      state_q     <= state_d;
      bits_q      <= bits_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      shift_q     <= shift_d;
      key_q       <= key_d;
      sample_q    <= sample_d;
    end
  end
  assign key_reg     = key_q;
  assign sample      = sample_q;
  assign frame_error = err_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: scoreboard bench driving PS/2 frames into ps2_keyboard_rx
module tb_ps2_keyboard_rx;
  localparam int T = 200;
  logic clock = 0, reset = 1, ps2_clk = 1, ps2_data = 1;
  logic [7:0] key_reg;
  logic sample, frame_error;
  int n_tests = 0, n_fail = 0, cyc = 0, err_cnt = 0, last_fall = 0;
  logic [7:0] exp_q[$];
  bit chk_lat = 0, chk_to = 0;
  logic prev_s = 0, prev_e = 0;
  ps2_keyboard_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_reg(key_reg), .sample(sample), .frame_error(frame_error)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clock) begin
    logic [7:0] e;
    if (!reset && sample !== prev_s) begin
      if (exp_q.size() == 0) check("spurious_toggle", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("key_reg", key_reg, e);
      end
      if (chk_lat) begin
        check("toggle_latency", cyc - last_fall, 3);
        chk_lat = 0;
      end
    end
    if (!reset && frame_error && !prev_e) begin
      err_cnt++;
      if (chk_to) begin
        n_tests++;
        if (cyc - last_fall < T + 2 || cyc - last_fall > T + 5) begin
          n_fail++;
          $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d", cyc - last_fall, T + 2, T + 5);
        end
        chk_to = 0;
      end
    end
    if (!reset && frame_error && prev_e) begin
      n_tests++;
      n_fail++;
      $display("FAIL err_width: frame_error high for more than one cycle");
    end
    prev_s = sample;
    prev_e = frame_error;
  end
  task automatic send_bit(bit b);
    @(negedge clock);
    ps2_data = b;
    repeat (4) @(negedge clock);
    ps2_clk = 0;
    last_fall = cyc;
    repeat (8) @(negedge clock);
    ps2_clk = 1;
    repeat (4) @(negedge clock);
  endtask
  task automatic frame(logic [7:0] b, bit bad_par = 0, bit stop = 1, int nbits = 11);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    ps2_data = 1;
    repeat (4) @(negedge clock);
  endtask
  task automatic key(logic [7:0] b, logic [7:0] a);
    exp_q.push_back(a);
    frame(b);
  endtask
  task automatic sb_empty(string name);
    check(name, exp_q.size(), 0);
  endtask
  initial begin
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    check("rst_key", key_reg, 0);
    check("rst_sample", sample, 0);
    check("rst_err", frame_error, 0);
    chk_lat = 1;
    key(8'h1C, 8'h61);
    check("lat_seen", chk_lat, 0);
    check("sample_after_a", sample, 1);
    sb_empty("pending_a");
    frame(8'h12); key(8'h1C, 8'h41); frame(8'hF0); frame(8'h1C);
    frame(8'hF0); frame(8'h12); key(8'h1C, 8'h61);
    sb_empty("pending_shift");
    check("sample_after_shift", sample, 1);
    frame(8'hE0); frame(8'h5A);
    check("ext_no_update", key_reg, 8'h61);
    key(8'h5A, 8'h0D);
    sb_empty("pending_enter");
    frame(8'h16, 1);
    check("parity_err", err_cnt, 1);
    check("parity_key_kept", key_reg, 8'h0D);
    key(8'h16, 8'h31);
    frame(8'h1C, 0, 0);
    check("stop_err", err_cnt, 2);
    check("stop_key_kept", key_reg, 8'h31);
    chk_to = 1;
    frame(8'h29, 0, 1, 5);
    repeat (T + 20) @(negedge clock);
    check("timeout_err", err_cnt, 3);
    check("timeout_seen", chk_to, 0);
    key(8'h29, 8'h20);
    sb_empty("pending_err");
    frame(8'h59); key(8'h16, 8'h31); key(8'h1A, 8'h5A);
    frame(8'hF0); frame(8'h59); key(8'h1A, 8'h7A);
    key(8'h66, 8'h08); frame(8'h76);
    check("unmapped_kept", key_reg, 8'h08);
    key(8'h1C, 8'h61); key(8'h1C, 8'h61);
    sb_empty("pending_misc");
    frame(8'h45, 0, 1, 6);
    reset = 1;
    repeat (2) @(negedge clock);
    check("midrst_key", key_reg, 0);
    check("midrst_sample", sample, 0);
    check("midrst_err", frame_error, 0);
    reset = 0;
    repeat (4) @(negedge clock);
    key(8'h45, 8'h30);
    check("post_rst_sample", sample, 1);
    check("err_total", err_cnt, 3);
    sb_empty("pending_final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
